// File: rtl/if_prefetch_pkg.sv
// Shared constants, FSM encoding and helpers for the instruction prefetch unit.
package if_prefetch_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [31:0] InstNop  = 32'h0000_0001;

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } pf_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_prefetch_inst_fifo.sv
// Instruction buffer for the prefetch unit: synchronous FIFO of {pc, inst} entries
// with flush, simultaneous push/pop and an occupancy count.
module if_prefetch_inst_fifo #(
  parameter int unsigned  DEPTH = 2,
  parameter int unsigned  WIDTH = 64,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned     PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign do_pop  = pop_i && !flush_i && (count_q != '0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i && !flush_i && ((count_q != DepthC) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: keeps up to DEPTH requests in flight on the instruction
// bus, buffers in-order responses and redirects on jumps by discarding stale responses.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int unsigned     CntW   = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  pf_state_e       state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [CntW-1:0] fifo_count;
  logic [63:0]     fifo_head;
  logic [CntW:0]   in_flight;
  logic            grant, rsp_valid, push, pop;

  // Buffer slots are reserved at request time, so the FIFO can never overflow.
  assign in_flight = {1'b0, outst_q} + {1'b0, fifo_count};
  assign req_o     = (state_q != StBoot) && (in_flight < {1'b0, DepthC});
  assign addr_o    = fetch_pc_q;
  assign grant     = req_o && gnt_i;

  // A response with nothing outstanding cannot belong to this request stream.
  assign rsp_valid = rvalid_i && (outst_q != '0);
  assign push      = rsp_valid && (discard_q == '0) && !jump_flag_i;

  assign inst_valid_o = (fifo_count != '0) && !jump_flag_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? fifo_head[31:0] : InstNop;
  assign inst_addr_o  = inst_valid_o ? fifo_head[63:32] : ZeroWord;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    unique case ({grant, rsp_valid})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end

    // Everything still in flight after this cycle belongs to the old path.
    if (jump_flag_i) begin
      fetch_pc_d = word_align(jump_addr_i);
      rsp_pc_d   = word_align(jump_addr_i);
      discard_d  = outst_d;
    end

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun, StDrain: begin
        if (jump_flag_i) begin
          state_d = (outst_d != '0) ? StDrain : StRun;
        end else if ((state_q == StDrain) && (discard_d == '0)) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  if_prefetch_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) inst_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (jump_flag_i),
    .push_i  (push),
    .data_i  ({rsp_pc_q, rdata_i}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

`ifndef SYNTHESIS
  // Responses to requests abandoned by reset may still trail into BOOT.
  rvalid_has_owner_a: assert property (@(posedge clk) disable iff (!rst)
    (rvalid_i && (state_q != StBoot)) |-> (outst_q != '0));
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch: bus responder, program-order reference stream and
// a scoreboard monitor, plus directed boot, redirect, backpressure, wrap and reset cases.
module tb_if_prefetch;

  localparam logic [31:0] RstPc  = 32'h0000_0000;
  localparam int          Depth  = 2;
  localparam logic [31:0] ExpNop = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_prefetch #(
    .RESET_PC (RstPc),
    .DEPTH    (Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .req_o        (req_o),
    .addr_o       (addr_o),
    .gnt_i        (gnt_i),
    .rvalid_i     (rvalid_i),
    .rdata_i      (rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i)
  );

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} exp_t;

  int checks = 0;
  int errors = 0;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_tail;

  int unsigned gnt_pct = 100, rdy_pct = 100, jmp_pct = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int          cyc = 0;
  int          since_rel = 0;
  logic        rst_drv = 1'b0;
  logic        do_jump = 1'b0;
  logic        arm_busy = 1'b0;
  logic        arm_full = 1'b0;
  logic        jumped = 1'b0;
  logic [31:0] jmp_target = '0;

  int          pops = 0;
  int          grants = 0;
  logic        saw_wrap = 1'b0;
  logic [31:0] last_gaddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer-visible program order: sequential words from the last redirect point.
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{exp_tail, mem_word(exp_tail)});
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    exp_tail = a & ~32'h3;
    refill();
  endtask

  task automatic step();
    logic rv;
    @(negedge clk);
    cyc++;
    rst = rst_drv;
    if (!rst) since_rel = 0;
    else      since_rel++;
    gnt_i        = ($urandom_range(99) < gnt_pct);
    inst_ready_i = ($urandom_range(99) < rdy_pct);
    rv           = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    rvalid_i     = rv;
    rdata_i      = rv ? mem_word(pend_q[0].addr) : $urandom;
    jump_flag_i  = 1'b0;
    jump_addr_i  = $urandom;
    if (rst && since_rel >= 2) begin
      if (do_jump) begin
        jump_flag_i = 1'b1;
        jump_addr_i = jmp_target;
        do_jump     = 1'b0;
      end else if (arm_busy && req_o && gnt_i && rv) begin
        jump_flag_i = 1'b1;
        jump_addr_i = jmp_target;
        arm_busy    = 1'b0;
        jumped      = 1'b1;
      end else if (arm_full && pend_q.size() == Depth) begin
        jump_flag_i = 1'b1;
        jump_addr_i = jmp_target;
        arm_full    = 1'b0;
        jumped      = 1'b1;
      end else if ($urandom_range(99) < jmp_pct) begin
        jump_flag_i = 1'b1;
      end
    end
    if (rv) void'(pend_q.pop_front());
    #1;
    if (rst && req_o && gnt_i) begin
      pend_q.push_back('{addr_o, cyc + int'($urandom_range(lat_max, lat_min))});
    end
    if (!rst) restart(RstPc);
    else if (jump_flag_i) restart(jump_addr_i);
    refill();
  endtask

  // Monitor: compares DUT outputs with the reference stream and bus-level rules.
  logic        prev_ok = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, prev_jump = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_fetch = RstPc;
  exp_t        e;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check_b("rst_req", req_o, 1'b0);
      check_w("rst_addr", addr_o, RstPc);
      check_b("rst_valid", inst_valid_o, 1'b0);
      check_w("rst_inst", inst_o, ExpNop);
      check_w("rst_inst_addr", inst_addr_o, 32'h0);
      exp_fetch = RstPc;
      prev_ok   = 1'b0;
    end else begin
      if (prev_ok && prev_req && !prev_gnt && !prev_jump) begin
        check_b("req_hold", req_o, 1'b1);
        check_w("addr_hold", addr_o, prev_addr);
      end
      if (jump_flag_i) check_b("valid_on_jump", inst_valid_o, 1'b0);
      if (inst_valid_o) begin
        if (inst_ready_i) begin
          if (exp_q.size() == 0) begin
            check_b("scoreboard_empty", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_w("pop_addr", inst_addr_o, e.addr);
            check_w("pop_inst", inst_o, e.data);
            pops++;
          end
        end
      end else begin
        check_w("idle_inst", inst_o, ExpNop);
        check_w("idle_inst_addr", inst_addr_o, 32'h0);
      end
      if (req_o && gnt_i) begin
        check_w("grant_addr", addr_o, exp_fetch);
        check_b("outstanding_limit", pend_q.size() <= Depth, 1'b1);
        if (last_gaddr == 32'hFFFF_FFFC && addr_o == 32'h0) saw_wrap = 1'b1;
        last_gaddr = addr_o;
        exp_fetch  = exp_fetch + 32'd4;
        grants++;
      end
      if (jump_flag_i) exp_fetch = jump_addr_i & ~32'h3;
      prev_ok = 1'b1;
    end
    prev_req  = req_o;
    prev_gnt  = gnt_i;
    prev_jump = jump_flag_i;
    prev_addr = addr_o;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, g0;
    restart(RstPc);
    repeat (3) step();

    // Boot: first request in the second cycle after release, then 0,4,8 in order.
    rst_drv = 1'b1;
    step();
    check_b("boot_req", req_o, 1'b0);
    step();
    check_b("first_req", req_o, 1'b1);
    check_w("first_addr", addr_o, RstPc);
    p0 = pops;
    repeat (6) step();
    #2;
    check_b("startup_pops", (pops - p0) >= 3, 1'b1);

    // Jump coinciding with a grant and a response, 1-cycle bus.
    jmp_target = 32'h0000_0100;
    jumped     = 1'b0;
    arm_busy   = 1'b1;
    for (int i = 0; i < 20 && !jumped; i++) step();
    check_b("armed_busy_jump", jumped, 1'b1);
    arm_busy = 1'b0;
    step();
    check_b("redir_req", req_o, 1'b1);
    check_w("redir_addr", addr_o, 32'h0000_0100);
    step();
    check_b("redir_n2_valid", inst_valid_o, 1'b0);
    step();
    check_b("redir_n3_valid", inst_valid_o, 1'b1);
    check_w("redir_n3_addr", inst_addr_o, 32'h0000_0100);
    repeat (5) step();

    // Jump with Depth requests in flight on a slow bus.
    lat_min  = 3;
    lat_max  = 3;
    jumped   = 1'b0;
    arm_full = 1'b1;
    for (int i = 0; i < 30 && !jumped; i++) step();
    check_b("armed_full_jump", jumped, 1'b1);
    arm_full = 1'b0;
    #2;
    p0 = pops;
    repeat (15) step();
    #2;
    check_b("drain_resume", pops > p0, 1'b1);

    // Consumer stalled: buffer fills, requests stop, nothing is lost afterwards.
    lat_min    = 1;
    lat_max    = 1;
    rdy_pct    = 0;
    jmp_target = 32'h0000_0200;
    do_jump    = 1'b1;
    step();
    #2;
    g0 = grants;
    repeat (10) step();
    #2;
    check_b("stall_grants", (grants - g0) <= Depth, 1'b1);
    check_b("stall_req_off", req_o, 1'b0);
    check_b("stall_valid", inst_valid_o, 1'b1);
    rdy_pct = 100;
    repeat (10) step();

    // Fetch address wraps from the top of the address space.
    saw_wrap   = 1'b0;
    jmp_target = 32'hFFFF_FFF8;
    do_jump    = 1'b1;
    repeat (10) step();
    #2;
    check_b("addr_wrap", saw_wrap, 1'b1);

    // Reset mid-burst: outputs return to reset values in the same cycle.
    lat_min = 2;
    lat_max = 3;
    repeat (10) step();
    rst_drv = 1'b0;
    step();
    check_b("midrst_req", req_o, 1'b0);
    check_w("midrst_addr", addr_o, RstPc);
    check_b("midrst_valid", inst_valid_o, 1'b0);
    check_w("midrst_inst", inst_o, ExpNop);
    check_w("midrst_inst_addr", inst_addr_o, 32'h0);
    repeat (2) step();
    rst_drv = 1'b1;
    step();
    pend_q.delete();
    repeat (20) step();

    // Randomized traffic with random redirects.
    gnt_pct = 70;
    rdy_pct = 70;
    lat_min = 1;
    lat_max = 4;
    jmp_pct = 3;
    #2;
    p0 = pops;
    repeat (3000) step();
    #2;
    check_b("random_progress", (pops - p0) > 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
